tone_synth: RTL
===============

Name: tone_synth

Overview:
- Downstream of the sound manager. Consumes its EnableSound / frequency[3:0] pair and turns it into signed 16-bit audio samples for the audio codec interface.
- A note-index lookup drives a square-wave half-period divider.
- An attack/release amplitude envelope, stepped once per codec sample request, removes clicks at tone start and stop.
- Output samples are registered and handed off with a one-cycle valid strobe.

Parameters:
- AMP_MAX, 15'd8192: sustain amplitude (unsigned magnitude).
- AMP_STEP, 15'd256: amplitude change per sample_req during attack/release. AMP_MAX must be a multiple of AMP_STEP.

Ports:
- clk  in  1  system clock, 50 MHz.
- resetN  in  1  asynchronous active-low reset.
- EnableSound  in  1  tone request, level.
- frequency  in  4  note index 0..15.
- sample_req  in  1  one-cycle strobe from codec, nominally 48 kHz.
- audio_sample  out  16  signed two's-complement sample.
- sample_valid  out  1  one-cycle strobe; audio_sample is valid while high.
- tone_active  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset: clk and resetN as stated above; reset is asynchronous, active-low.
  - Outputs reset to audio_sample=0, sample_valid=0, tone_active=0.
  - Internals reset to: state=IDLE, amp=0, half_cnt=0, sq=1, note_q=0.
  - Reset asserted mid-tone clears everything immediately, with no release ramp.
- Note table: note_q selects HALF_PERIOD[note_q], a 17-bit count.
  - Table is equal-tempered, index 0 = C4 261.63 Hz, +1 semitone per index; count = round(50e6/(2·f)).
  - Required entries: [0]=95556, [3]=80353, [9]=56818, [15]=40177.
- Divider, when state != IDLE:
  - half_cnt decrements every clk.
  - When half_cnt==0: sq toggles, note_q <= frequency, half_cnt <= HALF_PERIOD[frequency]-1.
  - A frequency change therefore takes effect only at a half-period boundary, so the waveform is glitch-free.
- FSM. Transitions are evaluated every clk. Amplitude steps only on sample_req.
  - IDLE: when EnableSound=1, load note_q <= frequency, half_cnt <= HALF_PERIOD[frequency]-1, sq=1, then go to ATTACK.
  - ATTACK: on each sample_req, amp += AMP_STEP. When amp reaches AMP_MAX, go to SUSTAIN. If EnableSound=0, go to RELEASE.
  - SUSTAIN: amp holds at AMP_MAX. If EnableSound=0, go to RELEASE.
  - RELEASE: on each sample_req, amp -= AMP_STEP. If EnableSound=1, go to ATTACK, continuing from the current amp. When amp reaches 0, go to IDLE with sq=1 and half_cnt=0.
  - amp saturates: it never exceeds AMP_MAX and never underflows below 0.
- Sample path:
  - On sample_req, audio_sample <= sq ? +amp : -amp, using the amp value before this cycle's step, sign-extended to 16 bits.
  - sample_valid <= 1 for exactly one cycle (latency 1 clk from sample_req). Otherwise sample_valid=0.
  - audio_sample holds its value between strobes.
  - In IDLE, a sample_req yields audio_sample=0 with sample_valid=1 (the codec always gets a sample).
- Simultaneous events:
  - sample_req in the same cycle as an FSM transition: the step uses the old state, and the transition applies afterwards.
  - sample_req in the same cycle as a half_cnt==0 toggle: the sample uses the old sq.
- One-cycle EnableSound gaps cause a RELEASE/ATTACK bounce of at most one AMP_STEP. This is tolerated, not filtered.

Decomposition:
- Package tone_pkg contains:
  - the FSM state enum {IDLE, ATTACK, SUSTAIN, RELEASE};
  - the HALF_PERIOD[0:15] 17-bit constant array;
  - the sample width constant.
- One sub-module, tone_divider: holds half_cnt, sq and note_q. Inputs: run, load, frequency. Outputs: sq and a toggle pulse.
- The FSM, envelope and sample register stay in tone_synth.

Test Plan:
1. Reset, then sample_req every 1042 clks with EnableSound=0 -> sample_valid pulses 1 clk after each req, audio_sample=0, tone_active=0.
2. Step EnableSound=1, frequency=15 -> tone_active=1 the next cycle; sq toggles every 40177 clks; |audio_sample| rises 0,256,…,8192 over 32 reqs, then holds at 8192 (SUSTAIN).
3. frequency changes 15->9 mid half-period -> the current half-period completes at 40177 clks, and the next half-periods are 56818 clks; no short pulse appears.
4. EnableSound drops during SUSTAIN -> |audio_sample| falls by 256 per req to 0 over 32 reqs, then state=IDLE and tone_active=0.
5. EnableSound reasserted at amp=4096 during RELEASE -> ramps back up from 4096 to 8192 in 16 reqs; no jump to 0.
6. resetN pulled low mid-SUSTAIN, asynchronously (not clock-aligned) -> all outputs are 0 immediately; after release of reset with EnableSound=1, the attack restarts from amp=0.

Source files
------------

// File: rtl/tone_pkg.sv
// Shared types and constants for the square-wave tone synthesiser.
package tone_pkg;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned AMP_W    = 15;
  localparam int unsigned CNT_W    = 17;
  localparam int unsigned NOTE_W   = 4;

  typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} tone_state_e;

  // Half-period in 50 MHz clocks, equal-tempered from C4 upwards.
  localparam logic [CNT_W-1:0] HALF_PERIOD [16] = '{
    17'd95556, 17'd90193, 17'd85131, 17'd80353,
    17'd75843, 17'd71586, 17'd67569, 17'd63776,
    17'd60197, 17'd56818, 17'd53629, 17'd50619,
    17'd47778, 17'd45097, 17'd42566, 17'd40177
  };

endpackage

// File: rtl/tone_divider.sv
// Square-wave half-period divider; a new note is picked up only at a half-period boundary.
module tone_divider
  import tone_pkg::*;
(
  input  logic              clk,
  input  logic              resetN,
  input  logic              run,
  input  logic              load,
  input  logic [NOTE_W-1:0] frequency,
  output logic              sq,
  output logic              toggle_c
);

  logic [CNT_W-1:0]  half_cnt;
  logic [NOTE_W-1:0] note_q;
  logic [CNT_W-1:0]  reload;
  logic              unused_note;

  assign reload      = HALF_PERIOD[frequency] - CNT_W'(1);
  assign toggle_c    = run && (half_cnt == '0);
  assign unused_note = ^note_q;

  // Idle (neither run nor load) parks the divider at sq=1, half_cnt=0.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      half_cnt <= '0;
      sq       <= 1'b1;
      note_q   <= '0;
    end else if (load) begin
      note_q   <= frequency;
      half_cnt <= reload;
      sq       <= 1'b1;
    end else if (run) begin
      if (toggle_c) begin
        sq       <= ~sq;
        note_q   <= frequency;
        half_cnt <= reload;
      end else begin
        half_cnt <= half_cnt - CNT_W'(1);
      end
    end else begin
      sq       <= 1'b1;
      half_cnt <= '0;
    end
  end

endmodule

// File: rtl/tone_synth.sv
// Tone synthesiser: envelope FSM around a square-wave divider, emitting signed samples on codec request.
module tone_synth
  import tone_pkg::*;
#(
  parameter logic [AMP_W-1:0] AMP_MAX  = 15'd8192,
  parameter logic [AMP_W-1:0] AMP_STEP = 15'd256
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                EnableSound,
  input  logic [NOTE_W-1:0]   frequency,
  input  logic                sample_req,
  output logic [SAMPLE_W-1:0] audio_sample,
  output logic                sample_valid,
  output logic                tone_active
);

  tone_state_e         state, state_nxt;
  logic [AMP_W-1:0]    amp, amp_nxt;
  logic [SAMPLE_W-1:0] mag;
  logic                run, load, sq, toggle_c;
  logic                unused_toggle;

  tone_divider u_div (
    .clk      (clk),
    .resetN   (resetN),
    .run      (run),
    .load     (load),
    .frequency(frequency),
    .sq       (sq),
    .toggle_c (toggle_c)
  );

  assign unused_toggle = toggle_c;
  // The divider is parked on the same edge that the FSM enters IDLE.
  assign run = (state != IDLE) && (state_nxt != IDLE);
  assign mag = {1'b0, amp};

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_nxt;
  end

  // Amplitude steps from the current state; the transition lands afterwards.
  always_comb begin
    state_nxt = state;
    amp_nxt   = amp;
    load      = 1'b0;
    case (state)
      IDLE: begin
        amp_nxt = '0;
        if (EnableSound) begin
          load      = 1'b1;
          state_nxt = ATTACK;
        end
      end
      ATTACK: begin
        if (sample_req)
          amp_nxt = (amp >= AMP_MAX - AMP_STEP) ? AMP_MAX : amp + AMP_STEP;
        if (!EnableSound)           state_nxt = RELEASE;
        else if (amp_nxt == AMP_MAX) state_nxt = SUSTAIN;
      end
      SUSTAIN: begin
        amp_nxt = AMP_MAX;
        if (!EnableSound) state_nxt = RELEASE;
      end
      RELEASE: begin
        if (sample_req)
          amp_nxt = (amp <= AMP_STEP) ? '0 : amp - AMP_STEP;
        if (EnableSound)        state_nxt = ATTACK;
        else if (amp_nxt == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      amp          <= '0;
      audio_sample <= '0;
      sample_valid <= 1'b0;
      tone_active  <= 1'b0;
    end else begin
      amp          <= amp_nxt;
      sample_valid <= sample_req;
      tone_active  <= (state_nxt != IDLE);
      if (sample_req)
        audio_sample <= sq ? mag : SAMPLE_W'(0) - mag;
    end
  end

endmodule
